// File: rtl/sound_cmd_latch.sv
// Main-to-sound CPU command latch: 4-deep command FIFO, NMI doorbell with
// hold/gap pacing, and a periodic IRQ generator on the sound-CPU clock enable.
//
// state  | meaning
// IDLE   | queue empty, NMI low
// ASSERT | NMI high, hold timer running
// WAIT   | NMI high, waiting for the sound CPU to read
// GAP    | NMI low for the minimum gap before re-asserting
module sound_cmd_latch #(
    parameter int IRQ_PERIOD = 16384,
    parameter int NMI_HOLD   = 32
) (
    input  logic       CLK48M,
    input  logic       RESET,
    input  logic       SNDRQ,
    input  logic [7:0] SNDNO,
    input  logic       SCPU_CLKEN,
    input  logic       SCPU_RDACK,
    input  logic       IRQ_ACK,
    output logic [7:0] SCPU_DO,
    output logic       SCPU_NMI,
    output logic       SCPU_IRQ,
    output logic [2:0] FIFO_CNT,
    output logic       OVF
);

    localparam int TW = $clog2(NMI_HOLD + 1);
    localparam int CW = (IRQ_PERIOD > 1) ? $clog2(IRQ_PERIOD) : 1;
    localparam logic [TW-1:0] HOLD_LOAD = TW'(NMI_HOLD - 1);
    localparam logic [CW-1:0] IRQ_LAST  = CW'(IRQ_PERIOD - 1);

    typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_WAIT, S_GAP} nmi_state_t;

    logic [7:0]    mem_q [4];
    logic [1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_nxt;
    logic [2:0]    cnt_q, cnt_d;
    logic [7:0]    do_q, do_d;
    logic          ovf_q, ovf_d;
    logic          push, pop;
    nmi_state_t    st_q;
    logic          nmi_q;
    logic [TW-1:0] tmr_q;
    logic [CW-1:0] irq_cnt_q, irq_cnt_d;
    logic          irq_q, irq_d, irq_wrap;

    always_comb begin
        pop      = SCPU_RDACK && (cnt_q != 3'd0);
        push     = SNDRQ && ((cnt_q != 3'd4) || pop);
        rd_nxt   = rd_ptr_q + 2'd1;
        wr_ptr_d = push ? wr_ptr_q + 2'd1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_nxt : rd_ptr_q;
        cnt_d    = cnt_q + {2'b00, push} - {2'b00, pop};
        ovf_d    = ovf_q | (SNDRQ && !push);
        do_d     = do_q;
        // The new head may be the byte being written this very cycle
        if (pop) begin
            if (cnt_d != 3'd0)
                do_d = (push && (wr_ptr_q == rd_nxt)) ? SNDNO : mem_q[rd_nxt];
        end else if (push && (cnt_q == 3'd0)) begin
            do_d = SNDNO;
        end

        irq_wrap  = SCPU_CLKEN && (irq_cnt_q == IRQ_LAST);
        irq_cnt_d = irq_cnt_q;
        if (SCPU_CLKEN)
            irq_cnt_d = irq_wrap ? '0 : irq_cnt_q + CW'(1);
        irq_d = irq_wrap | (irq_q & ~IRQ_ACK);
    end

    // Storage is deliberately left out of reset; the pointers define validity.
    always_ff @(posedge CLK48M) begin
        if (push)
            mem_q[wr_ptr_q] <= SNDNO;
    end

    always_ff @(posedge CLK48M or posedge RESET) begin
        if (RESET) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            do_q      <= '0;
            ovf_q     <= 1'b0;
            st_q      <= S_IDLE;
            nmi_q     <= 1'b0;
            tmr_q     <= '0;
            irq_cnt_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            do_q      <= do_d;
            ovf_q     <= ovf_d;
            irq_cnt_q <= irq_cnt_d;
            irq_q     <= irq_d;
            case (st_q)
                S_IDLE: begin
                    if (cnt_d != 3'd0) begin
                        st_q  <= S_ASSERT;
                        nmi_q <= 1'b1;
                        tmr_q <= HOLD_LOAD;
                    end
                end
                S_ASSERT, S_WAIT: begin
                    if (pop) begin
                        nmi_q <= 1'b0;
                        if (cnt_d == 3'd0) begin
                            st_q <= S_IDLE;
                        end else begin
                            st_q  <= S_GAP;
                            tmr_q <= HOLD_LOAD;
                        end
                    end else if (st_q == S_ASSERT) begin
                        if (tmr_q == '0)
                            st_q <= S_WAIT;
                        else
                            tmr_q <= tmr_q - TW'(1);
                    end
                end
                S_GAP: begin
                    if (tmr_q != '0) begin
                        tmr_q <= tmr_q - TW'(1);
                    end else if (cnt_d != 3'd0) begin
                        st_q  <= S_ASSERT;
                        nmi_q <= 1'b1;
                        tmr_q <= HOLD_LOAD;
                    end else begin
                        st_q <= S_IDLE;
                    end
                end
                default: begin
                    st_q  <= S_IDLE;
                    nmi_q <= 1'b0;
                end
            endcase
        end
    end

    assign SCPU_DO  = do_q;
    assign SCPU_NMI = nmi_q;
    assign SCPU_IRQ = irq_q;
    assign FIFO_CNT = cnt_q;
    assign OVF      = ovf_q;

endmodule
